// File: rtl/vga_cam_pkg.sv
// Shared constants and types for the camera-to-VGA bridge.
// The timing values are defaults; the top module can override them per instance.
package vga_cam_pkg;

  localparam int VGA_COL    = 1024;
  localparam int VGA_ROW    = 720;
  localparam int VGA_H_FP   = 24;
  localparam int VGA_H_SYNC = 136;
  localparam int VGA_H_BP   = 160;
  localparam int VGA_V_FP   = 3;
  localparam int VGA_V_SYNC = 6;
  localparam int VGA_V_BP   = 29;
  localparam int CAM_IMG_W  = 400;
  localparam int CAM_IMG_H  = 480;
  localparam int FS_AW      = 19;

  localparam int HCW = 11;  // holds 0..2047, enough for a 1344-cycle line
  localparam int VCW = 10;  // holds 0..1023, enough for a 758-line frame
  localparam int CCW = 11;  // camera x/y counters, saturating

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam logic [15:0] WHITE = 16'hFFFF;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with active-low sync and active-region flags.
// frame_wrap marks the cycle whose following edge returns the raster to (0,0).
module vga_timing
  import vga_cam_pkg::*;
#(
  parameter int COL    = VGA_COL,
  parameter int ROW    = VGA_ROW,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
)(
  input  logic           CLK,
  input  logic           RST,
  output logic [HCW-1:0] h_cnt,
  output logic [VCW-1:0] v_cnt,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           active,
  output logic           frame_wrap
);

  localparam logic [HCW-1:0] H_LAST = HCW'(COL + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(COL);
  localparam logic [HCW-1:0] HS_BEG = HCW'(COL + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(COL + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(ROW + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(ROW);
  localparam logic [VCW-1:0] VS_BEG = VCW'(ROW + V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(ROW + V_FP + V_SYNC);

  logic h_last;
  assign h_last = (h_cnt == H_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hsync_n    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vsync_n    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_wrap = h_last && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_camera_module.sv
// Camera (RGB565 over an 8-bit bus) to frame-store writer, plus VGA raster
// reader that streams the frame-store out with a fixed 2-cycle latency.
module vga_camera_module
  import vga_cam_pkg::*;
#(
  parameter int COL    = VGA_COL,
  parameter int ROW    = VGA_ROW,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter int IMG_W  = CAM_IMG_W,
  parameter int IMG_H  = CAM_IMG_H,
  parameter int AW     = FS_AW
)(
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmos_pclk,
  input  logic          cmos_vsyn,
  input  logic          cmos_href,
  input  logic [7:0]    cmos_data,
  output logic          cmos_xclk,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [15:0]   mem_rdata,
  output logic          HSYNC_Sig,
  output logic          VSYNC_Sig,
  output logic [R_W-1:0] Red_Sig,
  output logic [G_W-1:0] Green_Sig,
  output logic [B_W-1:0] Blue_Sig,
  output logic          led_o1,
  output logic          led_o2,
  output logic          led_o3
);

  localparam logic [CCW-1:0] CAM_W = CCW'(IMG_W);
  localparam logic [CCW-1:0] CAM_H = CCW'(IMG_H);
  localparam logic [HCW-1:0] RD_W  = HCW'(IMG_W);
  localparam logic [VCW-1:0] RD_H  = VCW'(IMG_H);

  // ---------------- camera capture ----------------
  logic [1:0]     pclk_q, vsyn_q, href_q;
  logic [7:0]     data_q1, data_q2;
  logic           pclk_d, vsyn_d, href_d;
  logic           pclk_rise, href_fall, vsyn_fall;
  logic           armed, phase, line_seen;
  logic [7:0]     hi_byte;
  logic [CCW-1:0] cam_x, cam_y;
  logic [AW-1:0]  wr_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pclk_q  <= '0;
      vsyn_q  <= '0;
      href_q  <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
      pclk_d  <= 1'b0;
      vsyn_d  <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      pclk_q  <= {pclk_q[0], cmos_pclk};
      vsyn_q  <= {vsyn_q[0], cmos_vsyn};
      href_q  <= {href_q[0], cmos_href};
      data_q1 <= cmos_data;
      data_q2 <= data_q1;
      pclk_d  <= pclk_q[1];
      vsyn_d  <= vsyn_q[1];
      href_d  <= href_q[1];
    end
  end

  assign pclk_rise = pclk_q[1] & ~pclk_d;
  assign href_fall = ~href_q[1] & href_d;
  assign vsyn_fall = ~vsyn_q[1] & vsyn_d;
  assign wr_addr   = AW'(32'(cam_y) * IMG_W + 32'(cam_x));

  // Capture stays disarmed after reset until the camera shows a vertical
  // blank, so a line interrupted by reset never produces a stray write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed     <= 1'b0;
      phase     <= 1'b0;
      line_seen <= 1'b0;
      hi_byte   <= '0;
      cam_x     <= '0;
      cam_y     <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      led_o1    <= 1'b0;
      led_o3    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (vsyn_q[1]) begin
        armed <= 1'b1;
        cam_x <= '0;
        cam_y <= '0;
        phase <= 1'b0;
      end else if (armed) begin
        if (href_fall) begin
          if (cam_y != '1) cam_y <= cam_y + 1'b1;
          cam_x     <= '0;
          phase     <= 1'b0;
          line_seen <= 1'b1;
        end else if (pclk_rise && href_q[1]) begin
          if (!phase) begin
            hi_byte <= data_q2;
          end else begin
            mem_we    <= (cam_x < CAM_W) && (cam_y < CAM_H);
            mem_waddr <= wr_addr;
            mem_wdata <= {hi_byte, data_q2};
            if (cam_x != '1) cam_x <= cam_x + 1'b1;
          end
          phase <= ~phase;
        end
      end
      if (vsyn_fall && line_seen) begin
        led_o1    <= ~led_o1;
        led_o3    <= 1'b1;
        line_seen <= 1'b0;
      end
    end
  end

  // ---------------- VGA readout ----------------
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           hsync_n, vsync_n, active, frame_wrap;
  logic           rd_hit, re_d1, hs_d1, vs_d1;
  rgb565_t        pix;

  vga_timing #(
    .COL(COL), .ROW(ROW),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .CLK        (CLK),
    .RST        (RST),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .active     (active),
    .frame_wrap (frame_wrap)
  );

  assign rd_hit    = active && (h_cnt < RD_W) && (v_cnt < RD_H);
  assign mem_re    = rd_hit & ~RST;
  assign mem_raddr = AW'(32'(v_cnt) * IMG_W + 32'(h_cnt));

  always_ff @(posedge CLK) begin
    if (RST) begin
      re_d1     <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      HSYNC_Sig <= 1'b1;
      VSYNC_Sig <= 1'b1;
      pix       <= rgb565_t'(WHITE);
      led_o2    <= 1'b0;
      cmos_xclk <= 1'b0;
    end else begin
      re_d1     <= mem_re;
      hs_d1     <= hsync_n;
      vs_d1     <= vsync_n;
      HSYNC_Sig <= hs_d1;
      VSYNC_Sig <= vs_d1;
      pix       <= re_d1 ? rgb565_t'(mem_rdata) : rgb565_t'(WHITE);
      if (frame_wrap) led_o2 <= ~led_o2;
      cmos_xclk <= ~cmos_xclk;
    end
  end

  assign Red_Sig   = pix.r;
  assign Green_Sig = pix.g;
  assign Blue_Sig  = pix.b;

endmodule

// File: tb/tb_vga_camera_module.sv
// Bench for vga_camera_module on a shrunken raster/image so several frames fit
// in a short run; random camera traffic is scored against a pixel-level model.
module tb_vga_camera_module;

  localparam int COL = 40, ROW = 12, H_FP = 4, H_SYNC = 8, H_BP = 8;
  localparam int V_FP = 2, V_SYNC = 3, V_BP = 3;
  localparam int IMG_W = 16, IMG_H = 10, AW = 19;
  localparam int HT = COL + H_FP + H_SYNC + H_BP;
  localparam int VT = ROW + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;

  logic          CLK = 1'b0, RST = 1'b1;
  logic          cmos_pclk = 1'b0, cmos_vsyn = 1'b0, cmos_href = 1'b0;
  logic [7:0]    cmos_data = '0;
  logic          cmos_xclk, mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic          HSYNC_Sig, VSYNC_Sig, led_o1, led_o2, led_o3;
  logic [4:0]    Red_Sig, Blue_Sig;
  logic [5:0]    Green_Sig;

  vga_camera_module #(
    .COL(COL), .ROW(ROW), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmos_pclk(cmos_pclk), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .cmos_xclk(cmos_xclk),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig),
    .Red_Sig(Red_Sig), .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig),
    .led_o1(led_o1), .led_o2(led_o2), .led_o3(led_o3)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [15:0] mem_fn(input int a);
    return 16'(a * 40503 + 777);
  endfunction

  // Frame-store read port: data one cycle after the strobe, noise otherwise.
  always @(posedge CLK)
    mem_rdata <= mem_re ? mem_fn(int'(mem_raddr)) : 16'($urandom);

  // Raster reference: cycles since reset determine every VGA output.
  int k;
  int vh, vv, ph, pv;
  always @(posedge CLK) if (RST) k <= 0; else k <= k + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      vh = k % HT;
      vv = (k / HT) % VT;
      check_val("mem_re", 32'(mem_re), 32'(vh < IMG_W && vv < IMG_H));
      if (vh < IMG_W && vv < IMG_H) check_val("mem_raddr", 32'(mem_raddr), vv * IMG_W + vh);
      check_val("xclk", 32'(cmos_xclk), k % 2);
      check_val("led_o2", 32'(led_o2), (k / FT) % 2);
      if (k >= 2) begin
        ph = (k - 2) % HT;
        pv = ((k - 2) / HT) % VT;
        check_val("hsync", 32'(HSYNC_Sig), 32'(!(ph >= COL + H_FP && ph < COL + H_FP + H_SYNC)));
        check_val("vsync", 32'(VSYNC_Sig), 32'(!(pv >= ROW + V_FP && pv < ROW + V_FP + V_SYNC)));
        check_val("rgb", {16'h0, Red_Sig, Green_Sig, Blue_Sig},
                  {16'h0, (ph < IMG_W && pv < IMG_H) ? mem_fn(pv * IMG_W + ph) : 16'hFFFF});
      end else begin
        check_val("hsync_early", 32'(HSYNC_Sig), 1);
        check_val("vsync_early", 32'(VSYNC_Sig), 1);
        check_val("rgb_early", {16'h0, Red_Sig, Green_Sig, Blue_Sig}, 32'hFFFF);
      end
    end
  end

  // Write scoreboard.
  typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t e;
  int n_writes = 0, max_waddr = 0, first_waddr = -1;

  always @(negedge CLK) begin
    if (!RST && mem_we) begin
      n_writes++;
      if (int'(mem_waddr) > max_waddr) max_waddr = int'(mem_waddr);
      if (first_waddr < 0) first_waddr = int'(mem_waddr);
      check_val("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(mem_waddr), 32'(e.a));
        check_val("wr_data", 32'(mem_wdata), 32'(e.d));
      end
    end
  end

  // Camera model state.
  int        m_y = 0, m_frames = 0;
  bit        m_line_pending = 0, m_led3 = 0;
  logic [7:0] lb [0:63];

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cam_vsync();
    cmos_vsyn = 1'b1;
    tick(6);
    cmos_vsyn = 1'b0;
    if (m_line_pending) begin
      m_frames++;
      m_led3 = 1'b1;
      m_line_pending = 1'b0;
    end
    m_y = 0;
    tick(6);
    check_val("led_o1", 32'(led_o1), m_frames % 2);
    check_val("led_o3", 32'(led_o3), 32'(m_led3));
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cmos_data = b;
    cmos_pclk = 1'b0;
    tick(2);
    cmos_pclk = 1'b1;
    tick(2);
  endtask

  task automatic cam_line(input int nbytes);
    cmos_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      cam_byte(lb[i]);
      if (i % 2 == 1 && m_y < IMG_H && i / 2 < IMG_W)
        exp_q.push_back(wr_t'({AW'(m_y * IMG_W + i / 2), lb[i-1], lb[i]}));
    end
    cmos_pclk = 1'b0;
    tick(2);
    cmos_href = 1'b0;
    tick(4);
    m_y++;
    m_line_pending = 1'b1;
    check_val("wr_drained", exp_q.size(), 0);
  endtask

  task automatic rand_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) lb[i] = 8'($urandom);
    cam_line(nbytes);
  endtask

  int w0, nl;

  initial begin
    // Reset values.
    tick(5);
    check_val("rst_hsync", 32'(HSYNC_Sig), 1);
    check_val("rst_vsync", 32'(VSYNC_Sig), 1);
    check_val("rst_rgb", {16'h0, Red_Sig, Green_Sig, Blue_Sig}, 32'hFFFF);
    check_val("rst_we", 32'(mem_we), 0);
    check_val("rst_re", 32'(mem_re), 0);
    check_val("rst_leds", {29'h0, led_o1, led_o2, led_o3}, 0);
    check_val("rst_xclk", 32'(cmos_xclk), 0);
    RST = 1'b0;

    // Directed line: two pixels A53C and 1234 at addresses 0 and 1.
    cam_vsync();
    lb[0] = 8'hA5; lb[1] = 8'h3C; lb[2] = 8'h12; lb[3] = 8'h34;
    w0 = n_writes;
    cam_line(4);
    check_val("dir_nwrites", n_writes - w0, 2);
    check_val("dir_first_addr", first_waddr, 0);
    check_val("dir_last_addr", max_waddr, 1);
    check_val("dir_last_data", 32'(mem_wdata), 32'h1234);
    cam_vsync();

    // Oversized frame: extra pixels and lines must be dropped.
    for (int l = 0; l < IMG_H + 3; l++) rand_line(2 * (IMG_W + 4));
    cam_vsync();
    check_val("bounds_max_addr", max_waddr, IMG_W * IMG_H - 1);

    // Random frames with random line lengths, including odd byte counts.
    for (int f = 0; f < 3; f++) begin
      nl = $urandom_range(1, IMG_H + 3);
      for (int l = 0; l < nl; l++) rand_line($urandom_range(1, 2 * (IMG_W + 4)));
      cam_vsync();
    end

    // Reset in the middle of a pixel: no write, next frame starts at address 0.
    cmos_href = 1'b1;
    cam_byte(8'hAA);
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    exp_q.delete();
    m_y = 0; m_frames = 0; m_led3 = 1'b0; m_line_pending = 1'b0;
    w0 = n_writes;
    cam_byte(8'hBB);
    cam_byte(8'hCC);
    cam_byte(8'hDD);
    cmos_pclk = 1'b0;
    tick(2);
    cmos_href = 1'b0;
    tick(6);
    check_val("rst_mid_no_write", n_writes - w0, 0);
    check_val("rst_mid_led1", 32'(led_o1), 0);
    cam_vsync();
    first_waddr = -1;
    rand_line(6);
    check_val("rst_mid_first_addr", first_waddr, 0);
    cam_vsync();

    // Let the raster run through two more full frames.
    tick(2 * FT + 50);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_camera_module.md
Name: vga_camera_module

Overview:
Single-clock camera-to-VGA bridge. Captures an 8-bit-bus RGB565 camera stream (two bytes per pixel) and writes pixels to an external frame-store through a simple write port. Generates VGA timing and reads the same frame-store back through a read port to drive RGB565 and sync outputs. Sits between the camera pins and the external memory controller/VGA DAC at the top of the display path.

Parameters:
COL, 1024, VGA active pixels per line
ROW, 720, VGA active lines per frame
H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal porch and sync widths in CLK cycles (line total 1344)
V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porch and sync widths in lines (frame total 758)
IMG_W, 400, captured image width in pixels
IMG_H, 480, captured image height in lines
AW, 19, frame-store address width

Ports:
CLK  in  1  system and pixel clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
cmos_pclk  in  1  camera pixel clock, sampled as data
cmos_vsyn  in  1  camera frame sync, high = vertical blank
cmos_href  in  1  camera line valid
cmos_data  in  8  camera byte
cmos_xclk  out  1  camera master clock = CLK/2
mem_we  out  1  frame-store write strobe, one cycle
mem_waddr  out  AW  write address = y*IMG_W + x
mem_wdata  out  16  RGB565 write data
mem_re  out  1  frame-store read strobe
mem_raddr  out  AW  read address
mem_rdata  in  16  read data, valid exactly 1 cycle after mem_re
HSYNC_Sig  out  1  horizontal sync, active-low
VSYNC_Sig  out  1  vertical sync, active-low
Red_Sig  out  5  pixel red
Green_Sig  out  6  pixel green
Blue_Sig  out  5  pixel blue
led_o1  out  1  toggles per completed camera frame
led_o2  out  1  toggles per VGA frame
led_o3  out  1  sticky high after first completed camera frame

Behaviour:
- Reset: all counters 0; mem_we=mem_re=0; HSYNC/VSYNC=1; RGB=16'hFFFF; LEDs 0; cmos_xclk 0.
- Camera inputs pass through a 2-flop synchronizer. A pclk rising edge is detected as sync'd pclk 0->1; capture acts only on that edge.
- vsyn high: reset x, y and byte phase to 0. vsyn 1->0 (after at least one captured line) completes a frame: toggle led_o1 and set led_o3.
- On a pclk edge with href=1: phase 0 latches the byte as the high byte {R[4:0],G[5:3]}; phase 1 forms {high,byte}, and if x<IMG_W and y<IMG_H pulses mem_we for one CLK with waddr=y*IMG_W+x and wdata equal to that value. Then x++ and phase toggles.
- href 1->0: y++, x=0, phase=0. Lines beyond IMG_H and pixels beyond IMG_W are dropped with no write.
- The VGA h counter runs 0..1343 every CLK. v advances at h wrap, running 0..757.
- Active when h<COL and v<ROW. HSYNC is low for h in [COL+H_FP, COL+H_FP+H_SYNC). VSYNC is low for v in [ROW+V_FP, ROW+V_FP+V_SYNC).
- Stage 0: if h<IMG_W and v<IMG_H, assert mem_re with raddr=v*IMG_W+h.
- Stage 2 outputs register: RGB=mem_rdata if a read was issued, else 16'hFFFF (white for blanking and out-of-image).
- HSYNC and VSYNC are delayed by the same 2 cycles, so all outputs are aligned.
- led_o2 toggles when v wraps to 0.
- Write and read ports are independent. Same-address same-cycle ordering is the memory's responsibility.
- Reset mid-frame: the next frame starts clean, with no partial write pulse after RST.

Decomposition:
- Package vga_cam_pkg: timing constants, RGB565 field widths, WHITE=16'hFFFF.
- Sub-module vga_timing (h/v counters, sync, active flags).
- Capture logic stays in the top module.

Test Plan:
- Reset: hold RST 5 cycles. Expect HSYNC=VSYNC=1, RGB=FFFF, mem_we=0, LEDs 0.
- Timing: run 2 frames. Expect HSYNC low 136 cycles every 1344, VSYNC low 6 lines every 758, led_o2 toggling once per frame.
- Capture: vsyn pulse, then one line of href with bytes A5,3C,12,34. Expect writes at addr 0 data A53C and addr 1 data 1234, one mem_we per pixel.
- Bounds: 500 pixels per line, 490 lines. Expect no write with x>=400 or y>=480; max address 191999; led_o1 toggles and led_o3 sets at frame end.
- Readback: memory model returns addr-derived data. Expect RGB at h=0,v=0 equal to mem[0], 2 cycles after the counter; h=400 gives FFFF; blanking gives FFFF.
- Reset mid-capture: assert RST after byte phase 0. Expect no write; the next frame's first pixel lands at addr 0.
